// File: rtl/osf_pkg.sv
// Shared types and constants for the 3x3 order-statistics filter window controller.
package osf_pkg;

    localparam int WIN_SIZE = 3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } osf_state_t;

    // Pad select presented with each window: bit0 replicates the right column, bit1 the bottom row
    localparam logic [1:0] PAD_NONE   = 2'b00;
    localparam logic [1:0] PAD_RIGHT  = 2'b01;
    localparam logic [1:0] PAD_BOTTOM = 2'b10;
    localparam logic [1:0] PAD_CORNER = 2'b11;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
    } osf_flags_t;

endpackage

// File: rtl/osf_window_ctrl_if.sv
// Pixel-stream, line-buffer, window and result-marker signals of the window controller.
interface osf_window_ctrl_if #(
    parameter int COL_W = 11
);
    logic             s_valid;
    logic             s_ready;
    logic [COL_W-1:0] lb_addr;
    logic             lb_wr_en;
    logic             win_valid;
    logic [1:0]       win_pad;
    logic             m_valid;
    logic             m_sof;
    logic             m_eol;

    modport master (
        input  s_valid,
        output s_ready, lb_addr, lb_wr_en, win_valid, win_pad, m_valid, m_sof, m_eol
    );

    modport slave (
        output s_valid,
        input  s_ready, lb_addr, lb_wr_en, win_valid, win_pad, m_valid, m_sof, m_eol
    );
endinterface

// File: rtl/osf_valid_delay.sv
// Valid/sof/eol delay line matching the sorting network depth, with an empty flag.
// Latency: exactly PIPE_LAT cycles.
// Backpressure: none, shifts every cycle.
module osf_valid_delay
    import osf_pkg::*;
#(
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       arstn,
    input  osf_flags_t din,
    output osf_flags_t dout,
    output logic       empty
);

    osf_flags_t sr [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (!arstn) begin
            for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[PIPE_LAT-1];

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (sr[i].vld) empty = 1'b0;
        end
    end

endmodule

// File: rtl/osf_window_ctrl.sv
// Raster sequencer for the 3x3 sorter: line-buffer control, window strobe, re-timed frame markers.
// Latency: win_valid combinational with the accepted pixel; m_* follow PIPE_LAT cycles later.
// Backpressure: s_ready only in FILL/RUN (pad cycles drop it when OSF_BORDER_REPLICATE_EN); no downstream stall.
module osf_window_ctrl
    import osf_pkg::*;
#(
    parameter int COL_W    = 11,
    parameter int ROW_W    = 11,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic [COL_W-1:0]  cfg_width,
    input  logic [ROW_W-1:0]  cfg_height,
    input  logic              start,
    osf_window_ctrl_if.master bus,
    output logic              busy,
    output logic              done
);

`ifdef OSF_BORDER_REPLICATE_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    // First row/column whose accept completes a window (replicated borders start one earlier)
    localparam int FIRST = PAD_EN ? 1 : WIN_SIZE - 1;

    osf_state_t       state, state_nxt;
    logic [COL_W-1:0] col, w_q;
    logic [ROW_W-1:0] row, h_q;
    logic             pad_r;
    logic [COL_W:0]   pcnt;
    logic             acc, last_col, last_row;
    logic             real_win, flush_win, flush_pads_done, dly_empty;
    logic             sof_flag, eol_flag;
    osf_flags_t       flags_in, flags_out;

    assign last_col  = (col == w_q - COL_W'(1));
    assign last_row  = (row == h_q - ROW_W'(1));
    assign acc       = bus.s_valid & bus.s_ready;
    assign real_win  = acc && (row >= ROW_W'(FIRST)) && (col >= COL_W'(FIRST));
    assign flush_win = PAD_EN && (state == FLUSH) && (pcnt <= {1'b0, w_q});
    assign flush_pads_done = !PAD_EN || (pcnt > {1'b0, w_q});

    assign bus.s_ready   = ((state == FILL) || (state == RUN)) && !pad_r;
    assign bus.lb_addr   = col;
    assign bus.lb_wr_en  = acc;
    assign bus.win_valid = real_win | pad_r | flush_win;

    always_comb begin
        bus.win_pad = PAD_NONE;
        if (pad_r) begin
            bus.win_pad = PAD_RIGHT;
        end else if (flush_win) begin
            bus.win_pad = ((pcnt == '0) || (pcnt == {1'b0, w_q})) ? PAD_CORNER : PAD_BOTTOM;
        end
    end

    assign sof_flag = real_win && (row == ROW_W'(FIRST)) && (col == COL_W'(FIRST));
    assign eol_flag = PAD_EN ? bus.win_pad[0] : (real_win && last_col);
    assign flags_in = {bus.win_valid, sof_flag, eol_flag};

    osf_valid_delay #(.PIPE_LAT(PIPE_LAT)) u_dly (
        .clk   (clk),
        .arstn (arstn),
        .din   (flags_in),
        .dout  (flags_out),
        .empty (dly_empty)
    );

    assign bus.m_valid = flags_out.vld;
    assign bus.m_sof   = flags_out.sof;
    assign bus.m_eol   = flags_out.eol;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (acc && last_col && (row == ROW_W'(1))) state_nxt = RUN;
            RUN:     if (acc && last_col && last_row) state_nxt = FLUSH;
            FLUSH:   if (dly_empty && flush_pads_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            w_q   <= '0;
            h_q   <= '0;
            pad_r <= 1'b0;
            pcnt  <= '0;
        end else begin
            state <= state_nxt;
            // Right-pad slot after each row that closes a window row, except the last (handled in FLUSH)
            pad_r <= PAD_EN && acc && last_col && (row != '0) && !last_row;
            if ((state == IDLE) && start) begin
                w_q <= cfg_width;
                h_q <= cfg_height;
                col <= '0;
                row <= '0;
            end else if (acc) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (state == FLUSH) begin
                if (!flush_pads_done) pcnt <= pcnt + (COL_W+1)'(1);
            end else begin
                pcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_osf_window_ctrl.sv
// Scoreboard bench for osf_window_ctrl: driver predicts each result's cycle and markers, monitor pops on m_valid.
module tb_osf_window_ctrl;
    import osf_pkg::*;

    localparam int COL_W    = 11;
    localparam int ROW_W    = 11;
    localparam int PIPE_LAT = 4;

    typedef struct {
        int   at;
        logic sof;
        logic eol;
    } exp_t;

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic             start = 1'b0;
    logic [COL_W-1:0] cfg_width = '0;
    logic [ROW_W-1:0] cfg_height = '0;
    logic             busy, done;

    osf_window_ctrl_if #(.COL_W(COL_W)) bus ();

    osf_window_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_out = 0;
    int   n_done = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every result must match the oldest outstanding prediction
    always @(negedge clk) begin
        exp_t e;
        if (done) n_done++;
        if (arstn && bus.m_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output at cycle %0d: got m_valid=1 expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("out_cycle", cyc, e.at);
                check("out_sof", bus.m_sof, e.sof);
                check("out_eol", bus.m_eol, e.eol);
            end
        end
    end

    task automatic check_quiet(input string name);
        check(name, {bus.s_ready, bus.lb_wr_en, bus.win_valid, bus.win_pad, bus.m_valid,
                     bus.m_sof, bus.m_eol, busy, done, 21'(bus.lb_addr)}, 32'd0);
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps, input int inj_at);
        int   last_cyc, done_at, n0, d0, pix;
        bit   win;
        exp_t e;
        n0 = n_out;
        d0 = n_done;
        pix = 0;
        last_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_width = COL_W'(w);
        cfg_height = ROW_W'(h);
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (pix == inj_at) begin
                    start = 1'b1;
                    cfg_width = COL_W'(4);
                end
                bus.s_valid = 1'b1;
                #1;
                win = (r >= 2) && (c >= 2);
                check("s_ready", bus.s_ready, 1);
                check("busy", busy, 1);
                check("lb_addr", bus.lb_addr, c);
                check("lb_wr_en", bus.lb_wr_en, 1);
                check("win_valid", bus.win_valid, win);
                check("win_pad", bus.win_pad, 0);
                if (win) begin
                    e.at  = cyc + PIPE_LAT;
                    e.sof = (r == 2) && (c == 2);
                    e.eol = (c == w - 1);
                    sb.push_back(e);
                    last_cyc = cyc;
                end
                @(negedge clk);
                start = 1'b0;
                cfg_width = COL_W'(w);
                bus.s_valid = 1'b0;
                pix++;
                if (gaps) begin
                    #1;
                    check("gap_wr_en", bus.lb_wr_en, 0);
                    check("gap_win_valid", bus.win_valid, 0);
                    @(negedge clk);
                end
            end
        end
        // Last window drains PIPE_LAT cycles, one cycle to see the line empty, then DONE
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            check("flush_s_ready", bus.s_ready, 0);
            @(negedge clk);
        end
        check("done_cycle", done_at, last_cyc + PIPE_LAT + 2);
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("done_pulses", n_done - d0, 1);
        check("out_count", n_out - n0, (w - 2) * (h - 2));
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int d0;
        bus.s_valid = 1'b0;
        arstn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("reset_outputs");
        end
        arstn = 1'b1;

        send_frame(8, 6, 1'b0, -1);
        send_frame(8, 6, 1'b1, -1);
        send_frame(3, 3, 1'b0, -1);
        send_frame(8, 6, 1'b0, 25);

        // Abort mid-frame (row 2) with a 3-cycle reset
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        cfg_width = COL_W'(8);
        cfg_height = ROW_W'(6);
        @(negedge clk);
        start = 1'b0;
        bus.s_valid = 1'b1;
        repeat (20) @(negedge clk);
        arstn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("midframe_reset_outputs");
        end
        sb.delete();
        arstn = 1'b1;
        bus.s_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_quiet("after_abort_idle");
        end
        check("abort_no_done", n_done - d0, 0);

        send_frame(8, 6, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
